// File: rtl/tap_sequencer_pkg.sv
// Shared equalizer constants: tap count, phase width and sample width.
package tap_sequencer_pkg;

    localparam int unsigned EQ_TAPS = 64;
    localparam int unsigned EQ_PW   = 6;
    localparam int unsigned EQ_SW   = 16;

    typedef logic signed [EQ_SW-1:0] sample_t;

endpackage

// File: rtl/tap_sequencer_phase_counter.sv
// Tap phase counter with first/last phase decode for the equalizer tap sequencer.
module phase_counter
    import tap_sequencer_pkg::*;
#(
    parameter int unsigned TAPS = EQ_TAPS,
    parameter int unsigned PW   = EQ_PW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clk_enable,
    input  logic          flush,
    output logic [PW-1:0] phase,
    output logic          phase_0,
    output logic          phase_63
);

    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_d;

    // Advance on enabled cycles; TAPS is a power of two so wrap is plain truncation.
    always_comb begin
        phase_d = phase_q;
        if (flush) begin
            phase_d = '0;
        end else if (clk_enable) begin
            phase_d = phase_q + PW'(1);
        end
    end

    // Phase register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase    = phase_q;
    assign phase_0  = clk_enable && (phase_q == '0);
    assign phase_63 = clk_enable && (phase_q == PW'(TAPS - 1));

endmodule

// File: rtl/tap_sequencer.sv
// Equalizer tap sequencer: sample holding register, circular delay line and
// per-phase delayed-sample selection for the MAC stage.
module tap_sequencer
    import tap_sequencer_pkg::*;
#(
    parameter int unsigned TAPS = EQ_TAPS,
    parameter int unsigned PW   = EQ_PW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_enable,
    input  logic signed [EQ_SW-1:0] sample_in,
    input  logic                    sample_valid,
    input  logic                    flush,
    input  logic                    clear_flags,
    output logic [PW-1:0]           phase,
    output logic                    phase_0,
    output logic                    phase_63,
    output logic signed [EQ_SW-1:0] input_mux,
    output logic                    sample_req,
    output logic                    underrun,
    output logic                    overrun
);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    sample_t       hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic          underrun_q, underrun_d;
    logic          overrun_q, overrun_d;
    sample_t       dline_q [TAPS];

    logic          push_c;
    sample_t       push_val_c;
    logic [PW-1:0] wr_nxt_c;
    logic [PW-1:0] rd_idx_c;
    logic          ovr_set_c;
    logic          und_set_c;

    phase_counter #(
        .TAPS (TAPS),
        .PW   (PW)
    ) u_phase_counter (
        .clk        (clk),
        .rst        (rst),
        .clk_enable (clk_enable),
        .flush      (flush),
        .phase      (phase),
        .phase_0    (phase_0),
        .phase_63   (phase_63)
    );

    assign push_c   = phase_63 && !flush;
    assign wr_nxt_c = wr_ptr_q + PW'(1);
    assign rd_idx_c = wr_ptr_q - phase;

    // Select the pushed value and the holding-register / flag updates.
    always_comb begin
        push_val_c  = '0;
        ovr_set_c   = 1'b0;
        und_set_c   = 1'b0;
        wr_ptr_d    = wr_ptr_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (flush) begin
            wr_ptr_d    = '0;
            hold_d      = '0;
            hold_full_d = 1'b0;
        end else if (push_c) begin
            wr_ptr_d    = wr_nxt_c;
            hold_full_d = 1'b0;
            if (sample_valid) begin
                push_val_c = sample_in;
                ovr_set_c  = hold_full_q;
            end else if (hold_full_q) begin
                push_val_c = hold_q;
            end else begin
                und_set_c  = 1'b1;
            end
        end else if (sample_valid) begin
            hold_d      = sample_in;
            hold_full_d = 1'b1;
            ovr_set_c   = hold_full_q;
        end
        underrun_d = und_set_c || (underrun_q && !clear_flags);
        overrun_d  = ovr_set_c || (overrun_q && !clear_flags);
    end

    // Control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            underrun_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            underrun_q  <= underrun_d;
            overrun_q   <= overrun_d;
        end
    end

    // Delay line: written only on push (one entry) or flush (all entries).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(TAPS); i++) begin
                dline_q[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < int'(TAPS); i++) begin
                dline_q[i] <= '0;
            end
        end else if (push_c) begin
            dline_q[wr_nxt_c] <= push_val_c;
        end
    end

    assign input_mux  = dline_q[rd_idx_c];
    assign sample_req = phase_63;
    assign underrun   = underrun_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_tap_sequencer.sv
// Randomized and directed bench for tap_sequencer against a history-list model.
module tb_tap_sequencer;

    localparam int TAPS = 64;

    logic               clk = 1'b0;
    logic               rst;
    logic               clk_enable;
    logic signed [15:0] sample_in;
    logic               sample_valid;
    logic               flush;
    logic               clear_flags;
    logic [5:0]         phase;
    logic               phase_0;
    logic               phase_63;
    logic signed [15:0] input_mux;
    logic               sample_req;
    logic               underrun;
    logic               overrun;

    tap_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .clk_enable   (clk_enable),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .flush        (flush),
        .clear_flags  (clear_flags),
        .phase        (phase),
        .phase_0      (phase_0),
        .phase_63     (phase_63),
        .input_mux    (input_mux),
        .sample_req   (sample_req),
        .underrun     (underrun),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int clk_n  = 0;
    logic last_req;

    // Model: m_hist[k] is the sample pushed k pushes ago (x[n-k]).
    int                 m_ph;
    logic signed [15:0] m_hist [TAPS];
    logic signed [15:0] m_hold;
    logic               m_hf;
    logic               m_und;
    logic               m_ovr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h) at t=%0t", tag, got, got, exp, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = 0;
        for (int i = 0; i < TAPS; i++) m_hist[i] = '0;
        m_hold = '0;
        m_hf   = 1'b0;
        m_und  = 1'b0;
        m_ovr  = 1'b0;
    endtask

    task automatic model_step(input logic en, input logic v, input logic signed [15:0] din,
                              input logic fl, input logic cf);
        logic us, os, push;
        logic signed [15:0] val;
        us = 1'b0;
        os = 1'b0;
        if (fl) begin
            for (int i = 0; i < TAPS; i++) m_hist[i] = '0;
            m_hold = '0;
            m_hf   = 1'b0;
            m_ph   = 0;
        end else begin
            push = en && (m_ph == TAPS - 1);
            if (push) begin
                if (v) begin
                    val = din;
                    os  = m_hf;
                end else if (m_hf) begin
                    val = m_hold;
                end else begin
                    val = 16'sd0;
                    us  = 1'b1;
                end
                for (int i = TAPS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
                m_hist[0] = val;
                m_hf = 1'b0;
            end else if (v) begin
                os     = m_hf;
                m_hold = din;
                m_hf   = 1'b1;
            end
            if (en) m_ph = (m_ph + 1) % TAPS;
        end
        m_und = us ? 1'b1 : (cf ? 1'b0 : m_und);
        m_ovr = os ? 1'b1 : (cf ? 1'b0 : m_ovr);
    endtask

    task automatic check_outputs();
        check_eq("phase",      32'(phase),      32'(m_ph));
        check_eq("phase_0",    32'(phase_0),    32'(clk_enable && m_ph == 0));
        check_eq("phase_63",   32'(phase_63),   32'(clk_enable && m_ph == TAPS - 1));
        check_eq("sample_req", 32'(sample_req), 32'(clk_enable && m_ph == TAPS - 1));
        check_eq("input_mux",  32'(input_mux),  32'(m_hist[m_ph]));
        check_eq("underrun",   32'(underrun),   32'(m_und));
        check_eq("overrun",    32'(overrun),    32'(m_ovr));
        last_req = sample_req;
    endtask

    // One clock: drive at negedge, check, then advance the model at the posedge.
    task automatic cycle(input logic en, input logic v, input logic signed [15:0] din,
                         input logic fl, input logic cf);
        @(negedge clk);
        clk_enable   = en;
        sample_valid = v;
        sample_in    = din;
        flush        = fl;
        clear_flags  = cf;
        #1;
        check_outputs();
        @(posedge clk);
        clk_n++;
        model_step(en, v, din, fl, cf);
    endtask

    task automatic run_to_phase(input int target);
        int n;
        n = 0;
        while (m_ph != target && n < 3 * TAPS) begin
            cycle(1'b1, 1'b0, 16'sd0, 1'b0, 1'b0);
            n++;
        end
        check_eq("run_to_phase_timeout", 32'(m_ph), 32'(target));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        clk_enable   = 1'b0;
        sample_valid = 1'b0;
        sample_in    = '0;
        flush        = 1'b0;
        clear_flags  = 1'b0;
        #1;
        model_reset();
        check_outputs();
        clk_enable = 1'b1;
        #1;
        check_eq("rst_phase_0",  32'(phase_0),  32'd1);
        check_eq("rst_phase_63", 32'(phase_63), 32'd0);
        clk_enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int first_at;
        int npush;
        int push_clk [$];
        logic en, v, fl, cf;

        rst          = 1'b1;
        clk_enable   = 1'b0;
        sample_valid = 1'b0;
        sample_in    = '0;
        flush        = 1'b0;
        clear_flags  = 1'b0;
        last_req     = 1'b0;
        model_reset();

        // Free-running frame with no samples: one underrun push of zero.
        do_reset();
        for (int i = 0; i < TAPS; i++) cycle(1'b1, 1'b0, 16'sd0, 1'b0, 1'b0);
        #1;
        check_eq("s1_phase",    32'(phase),     32'd0);
        check_eq("s1_underrun", 32'(underrun),  32'd1);
        check_eq("s1_mux",      32'(input_mux), 32'd0);

        // Three held samples: newest at phase 0, oldest at phase 2.
        do_reset();
        cycle(1'b1, 1'b1, 16'sd1000, 1'b0, 1'b0);
        run_to_phase(TAPS - 1);
        cycle(1'b1, 1'b0, 16'sd0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 16'sd2000, 1'b0, 1'b0);
        run_to_phase(TAPS - 1);
        cycle(1'b1, 1'b0, 16'sd0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 16'sd3000, 1'b0, 1'b0);
        run_to_phase(TAPS - 1);
        cycle(1'b1, 1'b0, 16'sd0, 1'b0, 1'b0);
        #1 check_eq("s2_p0", 32'(input_mux), 32'd3000);
        cycle(1'b1, 1'b0, 16'sd0, 1'b0, 1'b0);
        #1 check_eq("s2_p1", 32'(input_mux), 32'd2000);
        cycle(1'b1, 1'b0, 16'sd0, 1'b0, 1'b0);
        #1 check_eq("s2_p2", 32'(input_mux), 32'd1000);
        cycle(1'b1, 1'b0, 16'sd0, 1'b0, 1'b0);
        #1 check_eq("s2_p3", 32'(input_mux), 32'd0);
        check_eq("s2_underrun", 32'(underrun), 32'd0);

        // Two strobes in one frame: overrun, newest value pushed.
        cycle(1'b1, 1'b1, 16'sd5, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 16'sd7, 1'b0, 1'b0);
        run_to_phase(TAPS - 1);
        cycle(1'b1, 1'b0, 16'sd0, 1'b0, 1'b0);
        #1;
        check_eq("s3_overrun", 32'(overrun),   32'd1);
        check_eq("s3_mux",     32'(input_mux), 32'd7);

        // Direct push of the most negative sample, no flags.
        cycle(1'b1, 1'b0, 16'sd0, 1'b0, 1'b1);
        run_to_phase(TAPS - 1);
        cycle(1'b1, 1'b1, -16'sd32768, 1'b0, 1'b0);
        #1;
        check_eq("s4_mux",      32'(input_mux), 32'hFFFF_8000);
        check_eq("s4_overrun",  32'(overrun),   32'd0);
        check_eq("s4_underrun", 32'(underrun),  32'd0);

        // Alternating enable: pushes every 128 clocks.
        npush = 0;
        for (int i = 0; i < 320; i++) begin
            cycle(1'(i % 2), 1'b0, 16'sd0, 1'b0, 1'b0);
            if (last_req) push_clk.push_back(clk_n);
        end
        check_eq("s5_push_count_ge2", 32'(push_clk.size() >= 2), 32'd1);
        for (int i = 1; i < push_clk.size(); i++)
            check_eq("s5_push_spacing", 32'(push_clk[i] - push_clk[i-1]), 32'd128);

        // Flush mid-frame: everything zero, flags retained until cleared.
        cycle(1'b1, 1'b1, 16'sd1234, 1'b0, 1'b0);
        run_to_phase(30);
        cycle(1'b1, 1'b1, 16'sd999, 1'b1, 1'b0);
        #1;
        check_eq("s6_phase",    32'(phase),     32'd0);
        check_eq("s6_mux",      32'(input_mux), 32'd0);
        check_eq("s6_underrun", 32'(underrun),  32'd1);
        for (int i = 0; i < TAPS; i++) cycle(1'b1, 1'b0, 16'sd0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 16'sd0, 1'b0, 1'b1);
        #1 check_eq("s6_cleared", 32'(underrun), 32'd0);

        // Reset mid-frame: first push only after a full frame of enables.
        cycle(1'b1, 1'b1, 16'sd42, 1'b0, 1'b0);
        run_to_phase(20);
        do_reset();
        first_at = -1;
        for (int n = 0; n < 2 * TAPS; n++) begin
            cycle(1'b1, 1'b0, 16'sd0, 1'b0, 1'b0);
            if (last_req) begin
                first_at = n;
                break;
            end
        end
        check_eq("s7_first_push", 32'(first_at), 32'(TAPS - 1));

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 3) != 0);
            v  = ($urandom_range(0, 7) == 0);
            fl = ($urandom_range(0, 499) == 0);
            cf = ($urandom_range(0, 39) == 0);
            cycle(en, v, 16'($urandom), fl, cf);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/tap_sequencer.md
TAP_SEQUENCER -- requirements
Module: tap_sequencer

Interface
REQ-001 Parameter: TAPS, 64, delay-line depth and phases per output sample; power of two.
REQ-002 Parameter: PW, 6, phase/pointer width, log2(TAPS).
REQ-003 clk  in  1  system clock.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 clk_enable  in  1  advances phase counter and delay line when 1.
REQ-006 sample_in  in  16  signed audio sample.
REQ-007 sample_valid  in  1  single-cycle strobe qualifying sample_in.
REQ-008 flush  in  1  synchronous clear of all state.
REQ-009 clear_flags  in  1  synchronous clear of the underrun and overrun flags.
REQ-010 phase  out  PW  current tap index, 0..TAPS-1, to the coefficient selector.
REQ-011 phase_0  out  1  phase==0 AND clk_enable.
REQ-012 phase_63  out  1  phase==TAPS-1 AND clk_enable.
REQ-013 input_mux  out  16  signed delayed sample for current tap, to MAC stage.
REQ-014 sample_req  out  1  one-cycle pulse, equal to phase_63; upstream may present next sample.
REQ-015 underrun  out  1  sticky: a push occurred with no sample held.
REQ-016 overrun  out  1  sticky: a held sample was overwritten before being pushed.

Function
REQ-017 Phase counter SHALL increment by 1 on each clk_enable=1 cycle and wrap TAPS-1 -> 0; it SHALL hold when clk_enable=0.
REQ-018 Delay line SHALL be a TAPS x 16 circular buffer with write pointer wr_ptr (PW bits) addressing the newest sample.
REQ-019 Push event = clk_enable=1 AND phase==TAPS-1; on push, wr_ptr <= wr_ptr+1 (mod TAPS) and the pushed value is written at wr_ptr+1.
REQ-020 input_mux SHALL be combinational: buffer[(wr_ptr - phase) mod TAPS], so phase k yields x[n-k] and the sample pushed at phase TAPS-1 appears at phase 0 of the next cycle.
REQ-021 Holding register: sample_valid=1 without push SHALL load sample_in into hold and set hold_full.
REQ-022 sample_valid=1 while hold_full=1 and no push SHALL overwrite hold and set overrun.
REQ-023 Push with hold_full=1 and sample_valid=0 SHALL push hold and clear hold_full.
REQ-024 Push with sample_valid=1 SHALL push sample_in directly, bypassing hold; if hold_full=1, set overrun; hold_full <= 0.
REQ-025 Push with hold_full=0 and sample_valid=0 SHALL push 16'sd0 and set underrun.
REQ-026 The buffer SHALL not be written outside push or flush.
REQ-027 flush=1 SHALL on the next edge zero all buffer entries, hold, hold_full, phase and wr_ptr; flush SHALL override clk_enable, push and sample_valid; flags are unaffected.
REQ-028 clear_flags=1 SHALL clear underrun and overrun; a same-cycle setting event SHALL take priority (flag set).
REQ-029 Latency: sample accepted at or before a push edge SHALL be output on input_mux at phase 0, one clk_enable cycle later; it SHALL then appear at phase k, TAPS push periods later it is overwritten.

Reset
REQ-030 rst=1 SHALL asynchronously clear phase, wr_ptr, hold, hold_full, underrun, overrun and every buffer entry to 0.
REQ-031 Therefore after reset input_mux=0, phase_0 = clk_enable, phase_63=0, sample_req=0.
REQ-032 Reset mid-frame SHALL discard the partial frame; the first push after release occurs after TAPS clk_enable cycles.

Structure
REQ-033 TAPS, PW and the 16-bit sample width SHALL be constants in the shared equalizer package, common with the coefficient selector and MAC stage.
REQ-034 The phase counter with phase_0/phase_63 decode SHALL be one sub-module, phase_counter, instantiated here; everything else is flat.

Verification
REQ-035 Reset, clk_enable=1 for 64 cycles, no samples -> phase 0..63 then 0; phase_0 high at cycles 0 and 64; one push of 0; underrun=1.
REQ-036 Present sample 1000 before the first push, then 2000, 3000 before the next pushes -> at phase 0/1/2 after the third push, input_mux = 3000/2000/1000; phase 3..63 give 0.
REQ-037 Two sample_valid strobes (5, 7) in one frame -> overrun=1; the next push writes 7.
REQ-038 sample_valid with -32768 on the push cycle while hold_full=0 -> pushed directly, no flags; at phase 0, input_mux = -32768.
REQ-039 clk_enable toggled 0/1 every cycle -> phase advances only on enabled cycles; pushes are spaced 128 clocks apart.
REQ-040 flush at phase 30 with the buffer populated -> next cycle phase=0, input_mux=0 for all phases; flags are retained until clear_flags is asserted.
